// File: rtl/alu_decoder_pkg.sv
// Shared constants for the ALU decoder: ALU operation codes, ALUOp classes,
// funct7 encodings of interest and the default Execute-stage reset code.
package alu_decoder_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] RESET_CTRL_DEFAULT = ALU_ADD;

endpackage

// File: rtl/alu_decoder_comb.sv
// Combinational ALU control decode with unsupported-encoding flag.
// Optional shift/XOR support is enabled by defining ALU_DEC_EXT_EN.
module alu_decoder_comb
    import alu_decoder_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] op,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    logic [2:0] ctrl_s;
    logic       ill_s;
    logic       f3_ill_s;

    // Decode ALUOp class, then funct3; R-type funct7 legality is layered on top
    always_comb begin
        ctrl_s   = ALU_ADD;
        ill_s    = 1'b0;
        f3_ill_s = 1'b0;
        case (ALUOp)
            ALUOP_LDST: begin
                ctrl_s = ALU_ADD;
                ill_s  = 1'b0;
            end
            ALUOP_BRANCH: begin
                ctrl_s = ALU_SUB;
                ill_s  = 1'b0;
            end
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] && funct7[5]) begin
                            ctrl_s = ALU_SUB;
                        end else begin
                            ctrl_s = ALU_ADD;
                        end
                    end
                    3'b010: ctrl_s = ALU_SLT;
                    3'b110: ctrl_s = ALU_OR;
                    3'b111: ctrl_s = ALU_AND;
`ifdef ALU_DEC_EXT_EN
                    3'b100: ctrl_s = ALU_XOR;
                    3'b001: ctrl_s = ALU_SLL;
                    3'b101: ctrl_s = ALU_SRL;
`endif
                    default: begin
                        ctrl_s   = ALU_ADD;
                        f3_ill_s = 1'b1;
                    end
                endcase
                // Only SUB may carry a non-zero funct7 on R-type; SRA falls out as illegal here
                if (op[5] && (funct7 != F7_ZERO) &&
                    !((funct7 == F7_ALT) && (funct3 == 3'b000))) begin
                    ill_s = 1'b1;
                end else begin
                    ill_s = f3_ill_s;
                end
            end
            default: begin
                ctrl_s = ALU_ADD;
                ill_s  = 1'b1;
            end
        endcase
    end

    assign ALUControl = ctrl_s;
    assign Illegal    = ill_s;

endmodule

// File: rtl/alu_decoder.sv
// ALU decoder top: combinational decode plus the Execute-stage pipeline register.
// Extended funct3 decode is selected with the ALU_DEC_EXT_EN macro.
module alu_decoder
    import alu_decoder_pkg::*;
#(
    parameter logic [2:0] RESET_CTRL = RESET_CTRL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] op,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [2:0] ALUControlE,
    output logic       IllegalE
);

    logic [2:0] ctrl_s;
    logic       ill_s;
    logic [2:0] ctrl_d, ctrl_q;
    logic       ill_d, ill_q;

    alu_decoder_comb u_comb (
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7     (funct7),
        .op         (op),
        .ALUControl (ctrl_s),
        .Illegal    (ill_s)
    );

    // Next state: flush inserts a bubble even while stalled
    always_comb begin
        ctrl_d = ctrl_q;
        ill_d  = ill_q;
        if (flush) begin
            ctrl_d = RESET_CTRL;
            ill_d  = 1'b0;
        end else if (en) begin
            ctrl_d = ctrl_s;
            ill_d  = ill_s;
        end else begin
            ctrl_d = ctrl_q;
            ill_d  = ill_q;
        end
    end

    // Execute-stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= RESET_CTRL;
            ill_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ill_q  <= ill_d;
        end
    end

    assign ALUControl  = ctrl_s;
    assign Illegal     = ill_s;
    assign ALUControlE = ctrl_q;
    assign IllegalE    = ill_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed cases then randomized traffic
// compared against a table-driven reference model of the decode and register.
module tb_alu_decoder;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic       clk = 1'b0;
    logic       reset, en, flush;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7, op;
    logic [2:0] ALUControl, ALUControlE;
    logic       Illegal, IllegalE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .flush       (flush),
        .ALUOp       (ALUOp),
        .funct3      (funct3),
        .funct7      (funct7),
        .op          (op),
        .ALUControl  (ALUControl),
        .Illegal     (Illegal),
        .ALUControlE (ALUControlE),
        .IllegalE    (IllegalE)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {Illegal, ALUControl} from a funct3-indexed table
    function automatic logic [3:0] ref_dec(input logic [1:0] aluop, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [6:0] opc);
        logic [2:0] ctrl_tbl [8];
        logic       ill_tbl  [8];
        logic [2:0] c;
        logic       il;
`ifdef ALU_DEC_EXT_EN
        ctrl_tbl = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
        ill_tbl  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        ctrl_tbl = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
        ill_tbl  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        if (aluop == 2'd0) return 4'h0;
        if (aluop == 2'd1) return 4'h1;
        if (aluop == 2'd3) return 4'h8;
        c  = ctrl_tbl[f3];
        il = ill_tbl[f3];
        if (f3 == 3'd0 && opc[5] && f7[5]) c = 3'd1;
        if (opc[5] && f7 != 7'd0 && !(f7 == 7'h20 && f3 == 3'd0)) il = 1'b1;
        return {il, c};
    endfunction

    task automatic drive(input logic [1:0] a, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [6:0] o);
        ALUOp = a; funct3 = f3; funct7 = f7; op = o;
    endtask

    initial begin
        logic [3:0] exp_reg;
        logic [3:0] exp_comb;
        reset = 1'b1; en = 1'b0; flush = 1'b0;
        ALUOp = 2'b00; funct3 = 3'bxxx; funct7 = 7'bxxxxxxx; op = 7'bxxxxxxx;
        #1;
        check("ldst_x_in_reset", {Illegal, ALUControl}, 4'h0);
        @(posedge clk); #1;
        check("reset_reg", {IllegalE, ALUControlE}, 4'h0);
        ALUOp = 2'b01; #1;
        check("branch_x", {Illegal, ALUControl}, 4'h1);

        drive(2'b10, 3'b000, 7'h20, OP_R); #1;
        check("r_sub", {Illegal, ALUControl}, 4'h1);
        drive(2'b10, 3'b000, 7'h00, OP_R); #1;
        check("r_add", {Illegal, ALUControl}, 4'h0);
        drive(2'b10, 3'b000, 7'b1010101, OP_I); #1;
        check("i_addi_f7_ignored", {Illegal, ALUControl}, 4'h0);
        drive(2'b10, 3'b000, 7'h20, OP_I); #1;
        check("i_addi_f7_alt", {Illegal, ALUControl}, 4'h0);
        drive(2'b10, 3'b010, 7'h00, OP_R); #1;
        check("slt", {Illegal, ALUControl}, 4'h5);
        drive(2'b10, 3'b110, 7'h00, OP_R); #1;
        check("or", {Illegal, ALUControl}, 4'h3);
        drive(2'b10, 3'b111, 7'h00, OP_R); #1;
        check("and", {Illegal, ALUControl}, 4'h2);
        drive(2'b10, 3'b111, 7'h01, OP_R); #1;
        check("and_bad_f7", {Illegal, ALUControl}, 4'hA);
`ifdef ALU_DEC_EXT_EN
        drive(2'b10, 3'b100, 7'h00, OP_R); #1;
        check("ext_xor", {Illegal, ALUControl}, 4'h4);
        drive(2'b10, 3'b001, 7'h00, OP_R); #1;
        check("ext_sll", {Illegal, ALUControl}, 4'h6);
        drive(2'b10, 3'b101, 7'h00, OP_R); #1;
        check("ext_srl", {Illegal, ALUControl}, 4'h7);
        drive(2'b10, 3'b101, 7'h20, OP_R); #1;
        check("ext_sra", {Illegal, ALUControl}, 4'hF);
        drive(2'b10, 3'b011, 7'h00, OP_R); #1;
        check("ext_011", {Illegal, ALUControl}, 4'h8);
`else
        for (int f = 0; f < 8; f++) begin
            logic [2:0] f3v;
            f3v = 3'(f);
            if (f3v == 3'b001 || f3v == 3'b011 || f3v == 3'b100 || f3v == 3'b101) begin
                drive(2'b10, f3v, 7'h00, OP_I); #1;
                check($sformatf("base_f3_%0d", f), {Illegal, ALUControl}, 4'h8);
            end
        end
`endif
        drive(2'b11, 3'b010, 7'h00, OP_R); #1;
        check("rsvd", {Illegal, ALUControl}, 4'h8);

        // Pipeline register behaviour
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b1;
        drive(2'b10, 3'b010, 7'h00, OP_R);
        @(posedge clk); #1;
        check("reg_capture", {IllegalE, ALUControlE}, 4'h5);
        en = 1'b0; drive(2'b10, 3'b110, 7'h00, OP_R);
        @(posedge clk); #1;
        check("reg_hold", {IllegalE, ALUControlE}, 4'h5);
        en = 1'b1; drive(2'b11, 3'b000, 7'h00, OP_R);
        @(posedge clk); #1;
        check("reg_ill_capture", {IllegalE, ALUControlE}, 4'h8);
        en = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("flush_over_stall", {IllegalE, ALUControlE}, 4'h0);
        flush = 1'b0; en = 1'b1; drive(2'b10, 3'b111, 7'h00, OP_R);
        @(posedge clk); #1;
        check("reg_capture_and", {IllegalE, ALUControlE}, 4'h2);
        reset = 1'b1; en = 1'b1; drive(2'b10, 3'b010, 7'h00, OP_R);
        @(posedge clk); #1;
        check("reset_over_en", {IllegalE, ALUControlE}, 4'h0);
        reset = 1'b0;

        // Randomized traffic against the reference model
        exp_reg = 4'h0;
        for (int i = 0; i < 400; i++) begin
            logic [1:0] a;
            logic [2:0] f3;
            logic [6:0] f7, o;
            a  = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       o = OP_R;
                1:       o = OP_I;
                default: o = 7'($urandom);
            endcase
            drive(a, f3, f7, o);
            reset = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            #1;
            exp_comb = ref_dec(a, f3, f7, o);
            check($sformatf("rand_comb_%0d", i), {Illegal, ALUControl}, exp_comb);
            if (reset || flush) exp_reg = 4'h0;
            else if (en)        exp_reg = exp_comb;
            @(posedge clk); #1;
            check($sformatf("rand_reg_%0d", i), {IllegalE, ALUControlE}, exp_reg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 Parameter: RESET_CTRL, default 3'b000, value loaded into ALUControlE on reset or flush.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  pipeline-register enable; 0 = stall (hold).
REQ-005 flush  input  1  synchronous bubble insert into pipeline register.
REQ-006 ALUOp  input  2  main-decoder class: 00 load/store, 01 branch, 10 R/I arithmetic, 11 reserved.
REQ-007 funct3  input  3  instruction bits [14:12].
REQ-008 funct7  input  7  instruction bits [31:25].
REQ-009 op  input  7  opcode bits [6:0]; op[5]=1 R-type, op[5]=0 I-type.
REQ-010 ALUControl  output  3  combinational ALU operation code.
REQ-011 Illegal  output  1  combinational flag: unsupported encoding.
REQ-012 ALUControlE  output  3  ALUControl registered into Execute stage.
REQ-013 IllegalE  output  1  Illegal registered into Execute stage.

Function
REQ-014 ALU codes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
REQ-015 ALUControl/Illegal SHALL be purely combinational, zero latency, no dependence on clk/reset.
REQ-016 ALUOp=00 SHALL give 000, Illegal=0, independent of funct3/funct7/op, including X/unknown values on those inputs.
REQ-017 ALUOp=01 SHALL give 001, Illegal=0, independent of funct3/funct7/op.
REQ-018 ALUOp=10, funct3=000: 001 when op[5]&funct7[5], else 000; funct7 ignored when op[5]=0.
REQ-019 ALUOp=10: funct3=010 -> 101; 110 -> 011; 111 -> 010.
REQ-020 ALUOp=10 with any other funct3 (base build) SHALL give 000 with Illegal=1.
REQ-021 ALUOp=10, op[5]=1: Illegal=1 if funct7 not 0000000, except funct7=0100000 with funct3=000; ALUControl per REQ-018/019 regardless.
REQ-022 ALUOp=11 SHALL give 000 with Illegal=1.
REQ-023 Register: reset or flush -> ALUControlE=RESET_CTRL, IllegalE=0; else en=1 -> capture ALUControl/Illegal; en=0 -> hold.
REQ-024 Priority: reset > flush > en; flush SHALL override a simultaneous stall.

Reset
REQ-025 Reset SHALL be synchronous, active-high; only ALUControlE/IllegalE are reset.
REQ-026 Combinational outputs SHALL remain valid during reset.

Configuration
REQ-027 Macro ALU_DEC_EXT_EN defined: ALUOp=10 funct3=100 -> 100, 001 -> 110, 101 -> 111, Illegal=0; funct3=101 with R-type funct7=0100000 (SRA) -> 111 with Illegal=1; funct3=011 -> 000 with Illegal=1.
REQ-028 Macro undefined: REQ-020 applies to funct3 001/011/100/101 (000, Illegal=1).

Structure
REQ-029 Shared package SHALL hold the ALU-code constants (REQ-014), ALUOp class constants and RESET_CTRL default.
REQ-030 One sub-module, alu_decoder_comb, SHALL hold REQ-016..022/027; top adds the Execute-stage register.

Verification
REQ-031 ALUOp=00, funct fields X -> ALUControl=000, Illegal=0; ALUOp=01 -> 001.
REQ-032 ALUOp=10, funct3=000, op=0110011: funct7=0100000 -> 001; 0000000 -> 000; op=0010011, funct7=1010101 -> 000, Illegal=0.
REQ-033 ALUOp=10, funct3=010/110/111 -> 101/011/010; funct3=001 base build -> 000, Illegal=1; ALUOp=11 -> 000, Illegal=1.
REQ-034 Ext build: funct3=100/001/101 (funct7=0) -> 100/110/111, Illegal=0; funct3=011 -> Illegal=1.
REQ-035 Register: reset -> ALUControlE=000; en=1 edge captures 101; en=0 holds 101 while input changes; flush with en=0 -> 000, IllegalE=0.
